// File: rtl/systolic_pkg.sv
// Shared types and helpers for the N x N output-stationary systolic multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width that holds N signed or unsigned DW x DW products without wrapping.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Row-major element offset of (i, j) in an n x n matrix.
    function automatic int idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element: a multiply-accumulate that also forwards A right and B down.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 34,
    parameter bit SIGNED = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [DW-1:0] a_in_i,
    input  logic [DW-1:0] b_in_i,
    output logic [DW-1:0] a_out_o,
    output logic [DW-1:0] b_out_o,
    output logic [AW-1:0] acc_o
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   prod_ext;
    logic [AW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;

    // The full-width product is formed first, then sign- or zero-extended to AW.
    if (SIGNED) begin : g_signed
        always_comb begin
            prod     = $unsigned($signed({{DW{a_in_i[DW-1]}}, a_in_i}) *
                                 $signed({{DW{b_in_i[DW-1]}}, b_in_i}));
            prod_ext = AW'($signed(prod));
        end
    end else begin : g_unsigned
        always_comb begin
            prod     = {{DW{1'b0}}, a_in_i} * {{DW{1'b0}}, b_in_i};
            prod_ext = AW'(prod);
        end
    end

    always_comb begin
        a_d   = en_i ? a_in_i : '0;
        b_d   = en_i ? b_in_i : '0;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out_o = a_q;
    assign b_out_o = b_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// N x N output-stationary systolic matrix multiplier: C = A*B or C += A*B.
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int AW     = acc_w(DW, N),
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              acc_en_i,
    input  logic [N*N*DW-1:0] a_flat_i,
    input  logic [N*N*DW-1:0] b_flat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N*N*AW-1:0] c_flat_o
);

    localparam int             KW     = $clog2(3 * N);
    localparam logic [KW-1:0]  K_LAST = KW'(3 * N - 3);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N*N*DW-1:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d;
    logic              run;
    logic              clr;

    // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    k_d     = '0;
                    a_buf_d = a_flat_i;
                    b_buf_d = b_flat_i;
                    clr     = !acc_en_i;
                end
            end
            RUN: begin
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand buffers are plain registers, not a RAM, so they take the async reset like everything else.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_buf_q <= '0;
            b_buf_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
        end
    end

    assign run    = (state_q == RUN);
    assign busy_o = run;
    assign done_o = (state_q == DONE);

    // Diagonal skew: row i sees A[i][k-i], column j sees B[k-j][j], zero outside the band.
    logic [DW-1:0] a_skew [N];
    logic [DW-1:0] b_skew [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_skew[i] = '0;
            b_skew[i] = '0;
            for (int t = 0; t < N; t++) begin
                if (int'(k_q) == i + t) begin
                    a_skew[i] = a_buf_q[idx(i, t, N)*DW +: DW];
                    b_skew[i] = b_buf_q[idx(t, i, N)*DW +: DW];
                end
            end
        end
    end

    logic [DW-1:0] a_h [N][N+1];
    logic [DW-1:0] b_v [N+1][N];

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_h[i][0] = a_skew[i];
        assign b_v[0][i] = b_skew[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_mac_pe #(
                .DW     (DW),
                .AW     (AW),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .en_i    (run),
                .clr_i   (clr),
                .a_in_i  (a_h[i][j]),
                .b_in_i  (b_v[i][j]),
                .a_out_o (a_h[i][j+1]),
                .b_out_o (b_v[i+1][j]),
                .acc_o   (c_flat_o[idx(i, j, N)*AW +: AW])
            );
        end
    end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Self-checking bench: directed and random multiplies against a plain-arithmetic matrix model.
module tb_systolic_matmul_nxn;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 2 * DW + 2;
    localparam int NU  = 2;
    localparam int DWU = 8;
    localparam int AWU = 2 * DWU + 1;

    logic              clk;
    logic              rst_n;
    logic              start, acc_en;
    logic [N*N*DW-1:0] a_flat, b_flat;
    logic              busy, done;
    logic [N*N*AW-1:0] c_flat;

    logic                 start_u, acc_en_u;
    logic [NU*NU*DWU-1:0] a_flat_u, b_flat_u;
    logic                 busy_u, done_u;
    logic [NU*NU*AWU-1:0] c_flat_u;

    systolic_matmul_nxn #(.N(N), .DW(DW), .SIGNED(1'b1)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .acc_en_i (acc_en),
        .a_flat_i (a_flat),
        .b_flat_i (b_flat),
        .busy_o   (busy),
        .done_o   (done),
        .c_flat_o (c_flat)
    );

    systolic_matmul_nxn #(.N(NU), .DW(DWU), .SIGNED(1'b0)) u_dut_u (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start_u),
        .acc_en_i (acc_en_u),
        .a_flat_i (a_flat_u),
        .b_flat_i (b_flat_u),
        .busy_o   (busy_u),
        .done_o   (done_u),
        .c_flat_o (c_flat_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    longint ma [N][N], mb [N][N], mc [N][N];
    longint mau [NU][NU], mbu [NU][NU], mcu [NU][NU];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_main();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_flat[(i*N+k)*DW +: DW] = DW'(ma[i][k]);
                b_flat[(i*N+k)*DW +: DW] = DW'(mb[i][k]);
            end
    endtask

    task automatic model_main(input bit acc);
        longint s;
        longint mask;
        mask = (longint'(1) <<< AW) - 1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = acc ? mc[i][j] : 0;
                for (int t = 0; t < N; t++) s += ma[i][t] * mb[t][j];
                mc[i][j] = s & mask;
            end
    endtask

    task automatic chk_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s C[%0d][%0d]", tag, i, j),
                    64'(c_flat[(i*N+j)*AW +: AW]), 64'(mc[i][j]));
    endtask

    task automatic rand_main();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = longint'($signed(16'($urandom)));
                mb[i][j] = longint'($signed(16'($urandom)));
            end
    endtask

    task automatic ident_main();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4 * i + j + 1;
            end
    endtask

    task automatic scramble_inputs();
        for (int x = 0; x < N * N; x++) begin
            a_flat[x*DW +: DW] = DW'($urandom);
            b_flat[x*DW +: DW] = DW'($urandom);
        end
    endtask

    // One multiply on the main instance, optionally poking start mid-run and in the done cycle.
    task automatic run_main(input string tag, input bit acc, input bit pulse_mid, input bit pulse_done);
        int cyc, busy_cnt;
        bit got;
        @(negedge clk);
        drive_main();
        acc_en = acc;
        start  = 1'b1;
        @(posedge clk);
        model_main(acc);
        cyc = 0; busy_cnt = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (pulse_mid && cyc == 4) begin
                start  = 1'b1;
                acc_en = 1'b0;
                scramble_inputs();
            end
            if (done === 1'b1) got = 1'b1;
            else if (busy === 1'b1) busy_cnt++;
        end
        chk({tag, " done seen"}, 64'(got), 64'd1);
        chk({tag, " done edge"}, 64'(cyc - 1), 64'(3 * N - 2));
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(3 * N - 2));
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        chk_c(tag);
        if (pulse_done) begin
            start  = 1'b1;
            acc_en = 1'b0;
            scramble_inputs();
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done width"}, 64'(done), 64'd0);
        chk({tag, " idle after done"}, 64'(busy), 64'd0);
        if (pulse_done) begin
            repeat (2) @(negedge clk);
            chk({tag, " no restart"}, 64'(busy), 64'd0);
            chk_c({tag, " hold"});
        end
    endtask

    task automatic run_u(input string tag, input bit acc);
        int cyc;
        longint s;
        @(negedge clk);
        for (int i = 0; i < NU; i++)
            for (int k = 0; k < NU; k++) begin
                a_flat_u[(i*NU+k)*DWU +: DWU] = DWU'(mau[i][k]);
                b_flat_u[(i*NU+k)*DWU +: DWU] = DWU'(mbu[i][k]);
            end
        acc_en_u = acc;
        start_u  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NU; i++)
            for (int j = 0; j < NU; j++) begin
                s = acc ? mcu[i][j] : 0;
                for (int t = 0; t < NU; t++) s += mau[i][t] * mbu[t][j];
                mcu[i][j] = s & ((longint'(1) <<< AWU) - 1);
            end
        cyc = 0;
        @(negedge clk);
        start_u = 1'b0;
        while (done_u !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done seen"}, 64'(done_u), 64'd1);
        for (int i = 0; i < NU; i++)
            for (int j = 0; j < NU; j++)
                chk($sformatf("%s C[%0d][%0d]", tag, i, j),
                    64'(c_flat_u[(i*NU+j)*AWU +: AWU]), 64'(mcu[i][j]));
    endtask

    initial begin
        int cyc, d1, d2;
        rst_n = 1'b0; start = 1'b0; acc_en = 1'b0; a_flat = '0; b_flat = '0;
        start_u = 1'b0; acc_en_u = 1'b0; a_flat_u = '0; b_flat_u = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = 0;
        for (int i = 0; i < NU; i++) for (int j = 0; j < NU; j++) mcu[i][j] = 0;
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset c nonzero", 64'(|c_flat), 64'd0);
        chk("reset c_u nonzero", 64'(|c_flat_u), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Identity, then accumulate to 2B, then a fresh pass back to B.
        ident_main();
        run_main("ident", 1'b0, 1'b0, 1'b0);
        run_main("accum", 1'b1, 1'b0, 1'b0);
        run_main("clear", 1'b0, 1'b0, 1'b0);

        // Signed 2x2 embedded in the top-left corner.
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
        ma[0][0] = -1; ma[0][1] = 2;  ma[1][0] = 3;  ma[1][1] = -4;
        mb[0][0] = 5;  mb[0][1] = -6; mb[1][0] = -7; mb[1][1] = 8;
        run_main("signed", 1'b0, 1'b0, 1'b0);

        // Most-negative operands accumulated until the result wraps modulo 2^AW.
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = -32768; mb[i][j] = -32768; end
        run_main("wrap0", 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) run_main($sformatf("wrap%0d", p + 1), 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_main();
            run_main($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        rand_main();
        run_main("handshake", 1'b0, 1'b1, 1'b1);

        // Start held high: consecutive done pulses one full run+done+idle period apart.
        rand_main();
        @(negedge clk);
        drive_main();
        acc_en = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        model_main(1'b0);
        cyc = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        chk("b2b first done", 64'(d1), 64'(3 * N - 1));
        chk("b2b period", 64'(d2 - d1), 64'(3 * N));
        chk_c("b2b");

        for (int i = 0; i < NU; i++) for (int j = 0; j < NU; j++) begin mau[i][j] = 255; mbu[i][j] = 255; end
        run_u("uext", 1'b0);
        chk("uext literal", 64'(c_flat_u[0 +: AWU]), 64'd130050);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NU; i++) for (int j = 0; j < NU; j++) begin
                mau[i][j] = longint'($urandom_range(0, 255));
                mbu[i][j] = longint'($urandom_range(0, 255));
            end
            run_u($sformatf("urand%0d", r), 1'(r));
        end

        // Reset while k = 3: outputs must clear before any further clock edge.
        ident_main();
        @(negedge clk);
        drive_main();
        acc_en = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst c nonzero", 64'(|c_flat), 64'd0);
        chk("midrst c_u nonzero", 64'(|c_flat_u), 64'd0);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mc[i][j] = 0;
        chk_c("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_main("post_rst", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
